// File: rtl/flit_injector_if.sv
// Host-side flit stream: valid/ready handshake with payload, target VC and
// end-of-packet marker. The host drives the master side, the injector the slave.
interface flit_injector_if #(
  parameter int DATA_W = 64,
  parameter int VC_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [VC_W-1:0]   in_vc;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_vc,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_vc,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/flit_injector.sv
// Network-interface injection stage: converts a host flit stream into router
// channel flits {valid, head, tail, vc, data}, tracks per-VC credits that mirror
// the router input buffers, and only accepts a host flit when its VC has credit.
// The channel output is registered; no combinational path from host to router.
module flit_injector #(
  parameter int DATA_W     = 64,
  parameter int NUM_VCS    = 4,
  parameter int CRED_DEPTH = 8,
  parameter int MAX_FLITS  = 8,
  localparam int VC_W      = $clog2(NUM_VCS),
  localparam int CH_W      = 3 + VC_W + DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  flit_injector_if.slave       host,
  output logic [CH_W-1:0]      channel_out,
  input  logic [VC_W:0]        flow_ctrl_in,
  output logic [NUM_VCS-1:0]   credit_avail,
  output logic                 inj_error
);

  localparam int CNT_W  = $clog2(CRED_DEPTH + 1);
  localparam int FCNT_W = $clog2(MAX_FLITS + 1);
  localparam logic [CNT_W-1:0]  CRED_MAX  = CNT_W'(CRED_DEPTH);
  localparam logic [FCNT_W-1:0] FLITS_MAX = FCNT_W'(MAX_FLITS);

  typedef enum logic {IDLE, BODY} state_t;

  state_t                          state_q, state_d;
  logic [VC_W-1:0]                 cur_vc_q, cur_vc_d;
  logic [FCNT_W-1:0]               flit_cnt_q, flit_cnt_d;
  logic [NUM_VCS-1:0][CNT_W-1:0]   credit_q, credit_d;
  logic [CH_W-1:0]                 chan_q, chan_d;
  logic                            err_q, err_d;

  logic [VC_W-1:0]   sel_vc;
  logic              handshake;
  logic [FCNT_W-1:0] flit_num;
  logic              is_head;
  logic              is_tail;
  logic              force_tail;
  logic              ret_valid;
  logic [VC_W-1:0]   ret_vc;
  logic [NUM_VCS-1:0] overflow;

  // The VC is taken from the host only on a head flit; afterwards it is locked.
  assign sel_vc    = (state_q == IDLE) ? host.in_vc : cur_vc_q;
  // Ready is forced low while reset is held so the host never sees a spurious accept.
  assign host.in_ready = reset && (credit_q[sel_vc] != '0);
  assign handshake = host.in_valid && host.in_ready;

  assign ret_valid = flow_ctrl_in[VC_W];
  assign ret_vc    = flow_ctrl_in[VC_W-1:0];

  assign is_head    = (state_q == IDLE);
  assign flit_num   = is_head ? FCNT_W'(1) : flit_cnt_q + FCNT_W'(1);
  assign force_tail = !host.in_last && (flit_num == FLITS_MAX);
  assign is_tail    = host.in_last || force_tail;

  // Packet framing FSM and the registered channel word.
  always_comb begin
    state_d    = state_q;
    cur_vc_d   = cur_vc_q;
    flit_cnt_d = flit_cnt_q;
    chan_d     = '0;
    if (handshake) begin
      chan_d = {1'b1, is_head, is_tail, sel_vc, host.in_data};
      if (is_tail) begin
        state_d    = IDLE;
        flit_cnt_d = '0;
      end else begin
        state_d    = BODY;
        cur_vc_d   = sel_vc;
        flit_cnt_d = flit_num;
      end
    end
  end

  // Per-VC credit update: a send and a return on the same VC cancel out;
  // a return beyond the buffer depth is dropped and flagged.
  always_comb begin
    credit_d = credit_q;
    overflow = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (ret_valid && (ret_vc == VC_W'(v)) && !(handshake && (sel_vc == VC_W'(v)))) begin
        if (credit_q[v] == CRED_MAX) begin
          overflow[v] = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CNT_W'(1);
        end
      end else if (handshake && (sel_vc == VC_W'(v)) && !(ret_valid && (ret_vc == VC_W'(v)))) begin
        credit_d[v] = credit_q[v] - CNT_W'(1);
      end
    end
  end

  // Sticky error: credit overflow or a packet cut short at the length limit.
  always_comb begin
    err_d = err_q || (|overflow) || (handshake && force_tail);
  end

  // State registers; an asynchronous reset abandons any open packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_vc_q   <= '0;
      flit_cnt_q <= '0;
      credit_q   <= {NUM_VCS{CRED_MAX}};
      chan_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_vc_q   <= cur_vc_d;
      flit_cnt_q <= flit_cnt_d;
      credit_q   <= credit_d;
      chan_q     <= chan_d;
      err_q      <= err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VCS; gi++) begin : g_avail
      assign credit_avail[gi] = (credit_q[gi] != '0);
    end
  endgenerate

  assign channel_out = chan_q;
  assign inj_error   = err_q;

endmodule
